// File: rtl/regfile_pkg.sv
// Shared types and default geometry for the parametrised register file.
package regfile_pkg;

   // Scrub engine states
   typedef enum logic {
      IDLE  = 1'b0,
      SCRUB = 1'b1
   } scrub_state_t;

   // Default geometry used by the CPU top and the bench
   localparam int unsigned DEF_DATA_WIDTH = 64;
   localparam int unsigned DEF_ADDR_WIDTH = 5;
   localparam int unsigned DEF_ZERO_REG   = 31;

endpackage

// File: rtl/regfile_read_port.sv
// One combinational read port: address decode, zero-register masking, write bypass.
module regfile_read_port
   import regfile_pkg::*;
#(
   parameter int unsigned DATA_WIDTH  = DEF_DATA_WIDTH,
   parameter int unsigned ADDR_WIDTH  = DEF_ADDR_WIDTH,
   parameter bit          ZERO_REG_EN = 1'b1,
   parameter int unsigned ZERO_REG    = (2 ** ADDR_WIDTH) - 1,
   parameter bit          BYPASS_EN   = 1'b0
) (
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic                  wr_en,
   input  logic [ADDR_WIDTH-1:0] wr_addr,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic [DATA_WIDTH-1:0] entries [2 ** ADDR_WIDTH],
   output logic [DATA_WIDTH-1:0] data
);

   logic zero_rd;
   logic zero_wr;

   assign zero_rd = ZERO_REG_EN && (addr == ADDR_WIDTH'(ZERO_REG));
   assign zero_wr = ZERO_REG_EN && (wr_addr == ADDR_WIDTH'(ZERO_REG));

   // Array lookup, then zero mask, then forwarding of a same-cycle write
   always_comb begin
      data = entries[addr];
      if (zero_rd) begin
         data = '0;
      end
      if (BYPASS_EN && wr_en && (wr_addr == addr) && !zero_wr) begin
         data = wr_data;
      end
   end

endmodule

// File: rtl/register_file_param.sv
// Parametrised 2R/1W register file with zero register, bypass and a scrub engine.
// All state changes on the falling edge of Clk; Reset is asynchronous.
module register_file_param
   import regfile_pkg::*;
#(
   parameter int unsigned DATA_WIDTH  = DEF_DATA_WIDTH,
   parameter int unsigned ADDR_WIDTH  = DEF_ADDR_WIDTH,
   parameter bit          ZERO_REG_EN = 1'b1,
   parameter int unsigned ZERO_REG    = (2 ** ADDR_WIDTH) - 1,
   parameter bit          BYPASS_EN   = 1'b0
) (
   input  logic                  Clk,
   input  logic                  Reset,
   input  logic [ADDR_WIDTH-1:0] RA,
   input  logic [ADDR_WIDTH-1:0] RB,
   input  logic [ADDR_WIDTH-1:0] RW,
   input  logic [DATA_WIDTH-1:0] BusW,
   input  logic                  RegWr,
   input  logic                  Clear,
   output logic [DATA_WIDTH-1:0] BusA,
   output logic [DATA_WIDTH-1:0] BusB,
   output logic                  Busy
);

   localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   scrub_state_t          state;
   logic [ADDR_WIDTH-1:0] cnt;
   logic                  wr_ok;

   // A write lands only when idle, not entering a scrub, and not aimed at the zero entry
   assign wr_ok = RegWr && !Busy && !Clear &&
                  !(ZERO_REG_EN && (RW == ADDR_WIDTH'(ZERO_REG)));

   // Scrub FSM: walks the counter over every entry once, Busy mirrors SCRUB
   always_ff @(negedge Clk or posedge Reset) begin
      if (Reset) begin
         state <= IDLE;
         cnt   <= '0;
         Busy  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (Clear) begin
                  state <= SCRUB;
                  cnt   <= '0;
                  Busy  <= 1'b1;
               end
            end
            SCRUB: begin
               if (cnt == ADDR_WIDTH'(DEPTH - 1)) begin
                  state <= IDLE;
                  cnt   <= '0;
                  Busy  <= 1'b0;
               end else begin
                  cnt <= cnt + ADDR_WIDTH'(1);
               end
            end
            default: begin
               state <= IDLE;
               cnt   <= '0;
               Busy  <= 1'b0;
            end
         endcase
      end
   end

   // Storage: reset clears all, scrub clears one entry per edge, else normal write
   always_ff @(negedge Clk or posedge Reset) begin
      if (Reset) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            mem[i] <= '0;
         end
      end else if (state == SCRUB) begin
         mem[cnt] <= '0;
      end else if (wr_ok) begin
         mem[RW] <= BusW;
      end
   end

   regfile_read_port #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH),
      .ZERO_REG_EN(ZERO_REG_EN),
      .ZERO_REG   (ZERO_REG),
      .BYPASS_EN  (BYPASS_EN)
   ) u_port_a (
      .addr   (RA),
      .wr_en  (RegWr),
      .wr_addr(RW),
      .wr_data(BusW),
      .entries(mem),
      .data   (BusA)
   );

   regfile_read_port #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH),
      .ZERO_REG_EN(ZERO_REG_EN),
      .ZERO_REG   (ZERO_REG),
      .BYPASS_EN  (BYPASS_EN)
   ) u_port_b (
      .addr   (RB),
      .wr_en  (RegWr),
      .wr_addr(RW),
      .wr_data(BusW),
      .entries(mem),
      .data   (BusB)
   );

endmodule
